// File: rtl/video_mon_pkg.sv
// rtl/video_mon_pkg.sv - shared types and helpers for the video frame monitor
// FSM states, sync polarity normalisation and a width-generic CRC step.
package video_mon_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } mon_state_e;

  localparam int CRC_MAX_W  = 32;
  localparam int DATA_MAX_W = 32;

  function automatic logic norm_sync(input logic raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

  // Shifts data_w bits of data (MSB first) through a non-reflected CRC of width crc_w.
  function automatic logic [CRC_MAX_W-1:0] crc_next(
    input logic [CRC_MAX_W-1:0]  crc,
    input logic [DATA_MAX_W-1:0] data,
    input logic [CRC_MAX_W-1:0]  poly,
    input int                    crc_w,
    input int                    data_w
  );
    logic [CRC_MAX_W-1:0] c;
    logic                 fb;
    c  = crc;
    fb = 1'b0;
    for (int i = DATA_MAX_W - 1; i >= 0; i--) begin
      if (i < data_w) begin
        fb = c[5'(crc_w - 1)] ^ data[i];
        c  = c << 1;
        if (fb) c = c ^ poly;
      end
    end
    for (int j = 0; j < CRC_MAX_W; j++) begin
      if (j >= crc_w) c[j] = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/video_crc_engine.sv
// rtl/video_crc_engine.sv - per-pixel CRC register with init and enable
// crc_nxt exposes the value including the current pixel so a frame can close on it.
module video_crc_engine
  import video_mon_pkg::*;
#(
  parameter int              CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021,
  parameter int              DATA_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc,
  output logic [CRC_W-1:0]  crc_nxt
);

  logic [CRC_MAX_W-1:0] stepped;
  logic                 unused_hi;

  always_comb begin
    stepped = crc_next(CRC_MAX_W'(crc), DATA_MAX_W'(data), CRC_MAX_W'(CRC_POLY), CRC_W, DATA_W);
  end

  assign unused_hi = ^stepped;
  assign crc_nxt   = en ? stepped[CRC_W-1:0] : crc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= '1;
    end else if (init) begin
      crc <= '1;
    end else begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/video_frame_monitor.sv
// rtl/video_frame_monitor.sv - sync lock, line/frame measurement and frame CRC
// Counters advance only on pix_en; a vsync assertion closes the frame.
module video_frame_monitor
  import video_mon_pkg::*;
#(
  parameter int               COLOR_BITS      = 6,
  parameter int               H_START         = 48,
  parameter int               H_ACTIVE        = 160,
  parameter int               V_START         = 37,
  parameter int               V_ACTIVE        = 192,
  parameter int               CNT_W           = 12,
  parameter int               CRC_W           = 16,
  parameter logic [CRC_W-1:0] CRC_POLY        = 16'h1021,
  parameter int               SYNC_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [COLOR_BITS-1:0] pixel,
  input  logic                  clear,
  output logic                  locked,
  output logic                  frame_done,
  output logic [CRC_W-1:0]      frame_crc,
  output logic [CNT_W-1:0]      frame_lines,
  output logic [CNT_W-1:0]      line_period,
  output logic [15:0]           frame_count,
  output logic                  line_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_LEN   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_LEN   = CNT_W'(V_ACTIVE);

  mon_state_e           state, state_nxt;
  logic                 hs_n, vs_n, hs_q, vs_q, primed;
  logic                 hs_evt, vs_evt;
  logic [CNT_W-1:0]     h_cnt, v_cnt, h_plus1;
  logic                 period_valid, active, crc_en;
  logic [CRC_W-1:0]     crc, crc_nxt;

  assign hs_n   = norm_sync(hsync, SYNC_ACTIVE_LOW != 0);
  assign vs_n   = norm_sync(vsync, SYNC_ACTIVE_LOW != 0);
  assign hs_evt = pix_en & primed & hs_n & ~hs_q;
  assign vs_evt = pix_en & primed & vs_n & ~vs_q;

  // Unsigned offset compare gives the window test without a compare against zero.
  assign active  = ((h_cnt - H_LO) < H_LEN) && ((v_cnt - V_LO) < V_LEN);
  assign crc_en  = (state == LOCKED) & pix_en & active;
  assign h_plus1 = h_cnt + 1'b1;
  assign locked  = (state == LOCKED);

  video_crc_engine #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .DATA_W   (COLOR_BITS)
  ) u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (vs_evt),
    .en      (crc_en),
    .data    (pixel),
    .crc     (crc),
    .crc_nxt (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vs_evt) state_nxt = LOCKED;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      primed       <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      period_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_crc    <= '0;
      frame_lines  <= '0;
      line_period  <= '0;
      frame_count  <= '0;
      line_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        line_err    <= 1'b0;
        frame_count <= '0;
      end
      if (pix_en) begin
        hs_q   <= hs_n;
        vs_q   <= vs_n;
        primed <= 1'b1;
        if (state == SEARCH) begin
          if (vs_evt) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            period_valid <= 1'b0;
          end
        end else begin
          h_cnt <= (h_cnt == CNT_MAX) ? h_cnt : h_plus1;
          if (hs_evt) begin
            line_period  <= h_plus1;
            period_valid <= 1'b1;
            if (period_valid && (h_plus1 != line_period)) line_err <= 1'b1;
            if (!vs_evt) begin
              h_cnt <= '0;
              v_cnt <= (v_cnt == CNT_MAX) ? v_cnt : v_cnt + 1'b1;
            end
          end
          // vsync wins over a coincident hsync for the counters.
          if (vs_evt) begin
            frame_crc   <= crc_nxt;
            frame_lines <= v_cnt + 1'b1;
            frame_count <= clear ? 16'd1 : frame_count + 16'd1;
            frame_done  <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_frame_monitor.sv
// tb/tb_video_frame_monitor.sv - scoreboard bench for video_frame_monitor
module tb_video_frame_monitor;

  typedef struct {
    logic [15:0] crc;
    logic [11:0] lines;
    logic [11:0] period;
    logic [15:0] count;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, pix_en, hs, vs, clear;
  logic [5:0] pixel;
  logic       v_pix_en, v_vs;
  logic [7:0] v_pixel;

  logic        g_locked, g_done, g_err, p_locked, p_done, p_err, v_locked, v_done, v_err;
  logic [15:0] g_crc, p_crc, v_crc, g_cnt, p_cnt, v_cnt;
  logic [11:0] g_lines, p_lines, v_lines, g_per, p_per, v_per;

  exp_t q_g[$], q_p[$], q_v[$];
  exp_t ge, pe, ve;
  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;

  video_frame_monitor #(.H_START(2), .H_ACTIVE(4), .V_START(1), .V_ACTIVE(2)) u_g (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(~hs), .vsync(~vs), .pixel(pixel),
    .clear(clear), .locked(g_locked), .frame_done(g_done), .frame_crc(g_crc),
    .frame_lines(g_lines), .line_period(g_per), .frame_count(g_cnt), .line_err(g_err));

  video_frame_monitor #(.H_START(2), .H_ACTIVE(4), .V_START(1), .V_ACTIVE(2), .SYNC_ACTIVE_LOW(0)) u_p (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hs), .vsync(vs), .pixel(pixel),
    .clear(clear), .locked(p_locked), .frame_done(p_done), .frame_crc(p_crc),
    .frame_lines(p_lines), .line_period(p_per), .frame_count(p_cnt), .line_err(p_err));

  video_frame_monitor #(.COLOR_BITS(8), .H_START(0), .H_ACTIVE(9), .V_START(0), .V_ACTIVE(1)) u_v (
    .clk(clk), .rst_n(rst_n), .pix_en(v_pix_en), .hsync(1'b1), .vsync(~v_vs), .pixel(v_pixel),
    .clear(1'b0), .locked(v_locked), .frame_done(v_done), .frame_crc(v_crc),
    .frame_lines(v_lines), .line_period(v_per), .frame_count(v_cnt), .line_err(v_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_g_locked"}, g_locked, 0);
    chk({tag, "_g_crc"}, g_crc, 0);
    chk({tag, "_g_lines"}, g_lines, 0);
    chk({tag, "_g_period"}, g_per, 0);
    chk({tag, "_g_count"}, g_cnt, 0);
    chk({tag, "_g_err"}, g_err, 0);
    chk({tag, "_g_done"}, g_done, 0);
    chk({tag, "_p_locked"}, p_locked, 0);
    chk({tag, "_p_crc"}, p_crc, 0);
  endtask

  function automatic logic [15:0] m_crc(input logic [15:0] c_in, input logic [7:0] d, input int nb);
    logic [15:0] c;
    logic        top;
    c = c_in;
    for (int i = nb - 1; i >= 0; i--) begin
      top = c[15] ^ d[i];
      c   = {c[14:0], 1'b0};
      if (top) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [5:0] pix_val(input int l, input int h, input int seed);
    return 6'((l * 5 + h * 11 + seed) % 64);
  endfunction

  task automatic drive(input logic pe_i, input logic [5:0] px, input logic h_i, input logic v_i, input logic clr);
    @(negedge clk);
    pix_en = pe_i; pixel = px; hs = h_i; vs = v_i; clear = clr;
  endtask

  // Five lines of ten; hsync on the last cycle of each line, vsync with it on line 4.
  task automatic frame(input int seed, input int flip_l, input int flip_h, input int short_l,
                       input bit gap, input bit clr_short);
    logic [15:0] crc;
    logic [5:0]  px;
    int          len;
    exp_t        e;
    bit          last;
    crc = 16'hFFFF;
    for (int l = 0; l < 5; l++) begin
      len = (l == short_l) ? 9 : 10;
      for (int k = 0; k < len; k++) begin
        px = pix_val(l, k, seed) ^ ((l == flip_l && k == flip_h) ? 6'h01 : 6'h00);
        if (l >= 1 && l < 3 && k >= 2 && k < 6) crc = m_crc(crc, {2'b00, px}, 6);
        last = (k == len - 1);
        if (gap) drive(1'b0, 6'($urandom), 1'b1, 1'b1, 1'b0);
        drive(1'b1, px, last, last && l == 4, clr_short && l == short_l && last);
        if (l == short_l && last) begin
          if (clr_short) exp_count = 0;
          drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
          chk("g_line_err_on_short", g_err, 1);
          chk("p_line_err_on_short", p_err, 1);
        end
      end
    end
    exp_count++;
    e.crc = crc; e.lines = 12'd5; e.period = 12'd10; e.count = 16'(exp_count);
    q_g.push_back(e);
    q_p.push_back(e);
  endtask

  always @(negedge clk) begin
    if (g_done) begin
      if (q_g.size() == 0) begin
        checks++; errors++;
        $display("FAIL g_frame_done: got unexpected pulse required none");
      end else begin
        ge = q_g.pop_front();
        chk("g_frame_crc", g_crc, ge.crc);
        chk("g_frame_lines", g_lines, ge.lines);
        chk("g_line_period", g_per, ge.period);
        chk("g_frame_count", g_cnt, ge.count);
      end
    end
  end

  always @(negedge clk) begin
    if (p_done) begin
      if (q_p.size() == 0) begin
        checks++; errors++;
        $display("FAIL p_frame_done: got unexpected pulse required none");
      end else begin
        pe = q_p.pop_front();
        chk("p_frame_crc", p_crc, pe.crc);
        chk("p_frame_lines", p_lines, pe.lines);
        chk("p_line_period", p_per, pe.period);
        chk("p_frame_count", p_cnt, pe.count);
      end
    end
  end

  always @(negedge clk) begin
    if (v_done) begin
      if (q_v.size() == 0) begin
        checks++; errors++;
        $display("FAIL v_frame_done: got unexpected pulse required none");
      end else begin
        ve = q_v.pop_front();
        chk("v_frame_crc", v_crc, ve.crc);
        chk("v_frame_lines", v_lines, ve.lines);
        chk("v_line_period", v_per, ve.period);
        chk("v_frame_count", v_cnt, ve.count);
      end
    end
  end

  initial begin
    exp_t ev;
    rst_n = 1'b0; pix_en = 1'b0; hs = 1'b0; vs = 1'b0; clear = 1'b0; pixel = '0;
    v_pix_en = 1'b0; v_vs = 1'b0; v_pixel = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    // Known vector: "123456789" must give 0x29B1.
    @(negedge clk); v_pix_en = 1'b1; v_vs = 1'b0;
    @(negedge clk); v_vs = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); v_vs = 1'b0; v_pixel = 8'h31 + 8'(i);
    end
    @(negedge clk); v_vs = 1'b1; v_pixel = 8'h00;
    ev.crc = 16'h29B1; ev.lines = 12'd1; ev.period = 12'd0; ev.count = 16'd1;
    q_v.push_back(ev);
    @(negedge clk); v_vs = 1'b0; v_pix_en = 1'b0;
    @(negedge clk);
    chk("v_locked", v_locked, 1);

    // First pix_en only primes the edge registers.
    drive(1'b1, 6'h00, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("prime_g_locked", g_locked, 0);
    chk("prime_p_locked", p_locked, 0);

    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 10; k++) drive(1'b1, 6'h2A, k == 9, 1'b0, 1'b0);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("hs_only_locked", g_locked, 0);
    chk("hs_only_count", g_cnt, 0);

    drive(1'b1, 6'h00, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
    chk("lock_g_locked", g_locked, 1);
    chk("lock_p_locked", p_locked, 1);
    chk("lock_count", g_cnt, 0);

    frame(0, -1, -1, -1, 1'b0, 1'b0);
    frame(0, -1, -1, -1, 1'b0, 1'b0);
    frame(0, 1, 3, -1, 1'b0, 1'b0);
    frame(0, 1, 1, -1, 1'b0, 1'b0);
    frame(3, -1, -1, -1, 1'b1, 1'b0);
    chk("no_err_regular", g_err, 0);

    frame(0, -1, -1, 2, 1'b0, 1'b0);
    drive(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
    chk("err_sticky", g_err, 1);
    drive(1'b0, 6'h00, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
    exp_count = 0;
    chk("clear_g_err", g_err, 0);
    chk("clear_g_count", g_cnt, 0);
    chk("clear_p_err", p_err, 0);

    frame(5, -1, -1, -1, 1'b0, 1'b0);
    frame(0, -1, -1, 2, 1'b0, 1'b1);

    // Reset partway through line 1 discards the partial frame.
    for (int i = 0; i < 14; i++) drive(1'b1, pix_val(i / 10, i % 10, 0), i == 9, 1'b0, 1'b0);
    @(negedge clk); pix_en = 1'b0; hs = 1'b0; vs = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk_idle("midreset");
    exp_count = 0;
    drive(1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 6'h00, 1'b1, 1'b1, 1'b0);
    frame(0, -1, -1, -1, 1'b0, 1'b0);

    repeat (3) drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("q_g_drained", q_g.size(), 0);
    chk("q_p_drained", q_p.size(), 0);
    chk("q_v_drained", q_v.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_frame_monitor.md
Name: video_frame_monitor

Overview:
- Parametrised, synthesizable video-stream monitor for the Atari 2600 top-level test harness; taps the VGA-style output bus (hsync, vsync, RGB).
- Locks to sync and measures line period and lines per frame.
- Computes a CRC over the active pixels of each frame, so cocotb benches and on-chip self-test compare whole frames by one signature instead of pixel dumps.
- Successor to the plain harness wrapper: geometry, colour depth, CRC width and sync polarity are all configurable.

Parameters:
- COLOR_BITS, 6, pixel bits fed to CRC per active pixel (MSB first).
- H_START, 48, pixel clocks after hsync assertion before first active pixel.
- H_ACTIVE, 160, active pixels per line.
- V_START, 37, lines after vsync assertion before first active line.
- V_ACTIVE, 192, active lines per frame.
- CNT_W, 12, width of h/v counters and measurement outputs.
- CRC_W, 16, CRC width.
- CRC_POLY, 16'h1021, CRC polynomial, non-reflected, init all ones, no final XOR.
- SYNC_ACTIVE_LOW, 1, 1 = sync asserted when low.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- pix_en, in, 1, pixel strobe; all sampling gated by it.
- hsync, in, 1, horizontal sync, raw pin polarity.
- vsync, in, 1, vertical sync, raw pin polarity.
- pixel, in, COLOR_BITS, pixel colour.
- clear, in, 1, clears sticky error and frame_count.
- locked, out, 1, high after first vsync assertion.
- frame_done, out, 1, one-clk pulse when a frame completes.
- frame_crc, out, CRC_W, CRC of last completed frame.
- frame_lines, out, CNT_W, lines in last completed frame.
- line_period, out, CNT_W, pix_en cycles in last completed line.
- frame_count, out, 16, completed frames, wraps.
- line_err, out, 1, sticky: line period changed while locked.

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0, counters 0, CRC register all ones, state SEARCH. Same outcome mid-frame; the partial frame is discarded.
- Edge detection:
  - hs/vs are normalised by SYNC_ACTIVE_LOW, then registered on pix_en.
  - Assertion event = normalised low→high, seen on a pix_en cycle.
  - The first pix_en after reset only loads the edge registers; no event.
- FSM SEARCH:
  - Ignores hsync and pixels.
  - On vsync assertion → LOCKED: locked=1; h_cnt=0, v_cnt=0, CRC=all ones. No frame_done.
- FSM LOCKED, each pix_en cycle:
  - h_cnt increments, saturating at 2^CNT_W−1.
  - Pixel is active when H_START ≤ h_cnt < H_START+H_ACTIVE and V_START ≤ v_cnt < V_START+V_ACTIVE, with h_cnt taken before the increment. Active pixels advance the CRC by COLOR_BITS bits, MSB first.
- hsync assertion (LOCKED):
  - line_period ← h_cnt+1; h_cnt ← 0; v_cnt increments, saturating.
  - If a previous line_period was already captured since locking and the new value differs, line_err ← 1.
- vsync assertion (LOCKED):
  - frame_crc ← CRC including the current cycle's pixel if active.
  - frame_lines ← v_cnt+1; frame_count increments.
  - frame_done=1 for exactly one clk (next cycle).
  - CRC reset to all ones; h_cnt=0, v_cnt=0.
- hsync and vsync assert in the same cycle: vsync processing applies, hsync only updates line_period. The line_err comparison is still performed.
- clear: line_err←0, frame_count←0. If an error is set in the same cycle, set wins.
- pix_en low: no state changes except clear and reset. frame_done deasserts on the next clk regardless of pix_en.
- Latency: event sampled at edge N; outputs valid after edge N+1.

Decomposition:
- Shared package video_mon_pkg: FSM state enum (SEARCH, LOCKED), crc_next function (CRC_W, CRC_POLY, COLOR_BITS bits), sync normalisation helper.
- One sub-module, video_crc_engine: CRC register with init, enable and data inputs, one pixel per clock.

Test Plan:
- Known CRC vector. Params COLOR_BITS=8, H_START=0, H_ACTIVE=9, V_START=0, V_ACTIVE=1, pix_en=1. Stimulus: vsync, then one line carrying bytes "123456789" (0x31..0x39), then vsync. Required: frame_crc=0x29B1, frame_lines=1, single frame_done pulse.
- Lock behaviour. hsync pulses with no vsync → locked=0, frame_count=0. First vsync → locked=1, no frame_done. Second vsync → frame_done, frame_count=1.
- Geometry. H_START=2, H_ACTIVE=4, V_START=1, V_ACTIVE=2; line period 10, 5 lines per frame. Required: line_period=10, frame_lines=5. Two identical frames give equal frame_crc; flipping one active pixel changes it; flipping a pixel at h_cnt=1 leaves it unchanged.
- Error sticky. Shorten one line to 9 → line_err=1 and stays set. Assert clear → line_err=0, frame_count=0. clear coincident with a new mismatch → line_err=1.
- pix_en gating and polarity. pix_en toggled 1/0 → counts and CRC match the pix_en=1 run. SYNC_ACTIVE_LOW=0 with inverted syncs gives identical results.
- Reset mid-frame. rst_n low for 1 clk mid-line → all outputs 0, SEARCH. The next full frame's CRC matches the golden value.
